// File: rtl/alu_byte_sequencer.sv
// Frames A, B, Op bytes from the RX stream into ALU operand registers, then returns the ALU result to TX.
// o_tx_start pulses two cycles after the Op strobe; bytes that arrive while a result is in flight are dropped and flagged.
module alu_byte_sequencer #(
    parameter int N_BITS         = 8,
    parameter int N_OP           = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [N_OP-1:0]   o_alu_op,
    input  logic [N_BITS-1:0] i_alu_result,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    output logic              o_bad_op,
    output logic              o_timeout,
    output logic              o_overrun
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_DONE
    } state_t;

    state_t            state_q,    state_d;
    logic [N_BITS-1:0] alu_a_q,    alu_a_d;
    logic [N_BITS-1:0] alu_b_q,    alu_b_d;
    logic [N_OP-1:0]   alu_op_q,   alu_op_d;
    logic [N_BITS-1:0] tx_data_q,  tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              bad_op_q,   bad_op_d;
    logic              timeout_q,  timeout_d;
    logic              overrun_q,  overrun_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              cnt_expired;

    function automatic logic op_supported(input logic [N_OP-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            N_OP'(6'b100000), N_OP'(6'b100010), N_OP'(6'b100100), N_OP'(6'b100101),
            N_OP'(6'b100110), N_OP'(6'b000011), N_OP'(6'b000010), N_OP'(6'b100111): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign cnt_expired = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        bad_op_d   = bad_op_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        cnt_d      = '0;

        case (state_q)
            S_WAIT_A: begin
                if (i_rx_valid) begin
                    alu_a_d = i_rx_data;
                    state_d = S_WAIT_B;
                end
            end
            // A byte landing on the expiry cycle takes priority over the timeout.
            S_WAIT_B: begin
                if (i_rx_valid) begin
                    alu_b_d = i_rx_data;
                    state_d = S_WAIT_OP;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_OP: begin
                if (i_rx_valid) begin
                    alu_op_d = i_rx_data[N_OP-1:0];
                    state_d  = S_EXEC;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Registering tx_start here makes it high for exactly the SEND cycle.
            S_EXEC: begin
                tx_data_d  = i_alu_result;
                bad_op_d   = !op_supported(alu_op_q);
                tx_start_d = 1'b1;
                overrun_d  = i_rx_valid;
                state_d    = S_SEND;
            end
            S_SEND: begin
                overrun_d = i_rx_valid;
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                overrun_d = i_rx_valid;
                if (i_tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            bad_op_q   <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            bad_op_q   <= bad_op_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_bad_op   = bad_op_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer with a behavioural ALU and a short timeout.
module tb_alu_byte_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_res;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       bad_op;
    logic       timeout;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    alu_byte_sequencer #(
        .N_BITS(8),
        .N_OP(6),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_rx_data(rx_data),
        .i_rx_valid(rx_valid),
        .o_alu_a(alu_a),
        .o_alu_b(alu_b),
        .o_alu_op(alu_op),
        .i_alu_result(alu_res),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_done(tx_done),
        .o_bad_op(bad_op),
        .o_timeout(timeout),
        .o_overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_res = 8'h00;
        case (alu_op)
            6'b100000: alu_res = alu_a + alu_b;
            6'b100010: alu_res = alu_a - alu_b;
            6'b100100: alu_res = alu_a & alu_b;
            6'b100101: alu_res = alu_a | alu_b;
            6'b100110: alu_res = alu_a ^ alu_b;
            6'b000011: alu_res = $unsigned($signed(alu_a) >>> alu_b);
            6'b000010: alu_res = alu_a >> alu_b;
            6'b100111: alu_res = ~(alu_a | alu_b);
            default:   alu_res = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
        logic       bad;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Called in the cycle the Op byte is strobed; ends back in WAIT_A.
    task automatic send_rest(input string tag, input logic [7:0] opb, input logic [7:0] a,
                             input logic [7:0] b, input logic [5:0] op,
                             input logic [7:0] res, input logic bad);
        send_byte(opb);
        check({tag, ".start_early"}, 8'(tx_start), 8'h00);
        check({tag, ".alu_a"}, alu_a, a);
        check({tag, ".alu_b"}, alu_b, b);
        check({tag, ".alu_op"}, 8'(alu_op), 8'(op));
        tick();
        check({tag, ".start"}, 8'(tx_start), 8'h01);
        check({tag, ".tx_data"}, tx_data, res);
        check({tag, ".bad_op"}, 8'(bad_op), 8'(bad));
        tick();
        check({tag, ".start_width"}, 8'(tx_start), 8'h00);
        tick();
        check({tag, ".tx_hold"}, tx_data, res);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input logic [5:0] op,
                            input logic [7:0] res, input logic bad);
        send_byte(a);
        tick();
        tick();
        send_byte(b);
        tick();
        tick();
        send_rest(tag, opb, a, b, op, res, bad);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alu_a"}, alu_a, 8'h00);
        check({tag, ".alu_b"}, alu_b, 8'h00);
        check({tag, ".alu_op"}, 8'(alu_op), 8'h00);
        check({tag, ".tx_data"}, tx_data, 8'h00);
        check({tag, ".tx_start"}, 8'(tx_start), 8'h00);
        check({tag, ".bad_op"}, 8'(bad_op), 8'h00);
        check({tag, ".timeout"}, 8'(timeout), 8'h00);
        check({tag, ".overrun"}, 8'(overrun), 8'h00);
    endtask

    task automatic check_no_start(input string tag, input int n);
        logic ok;
        ok = 1'b1;
        repeat (n) begin
            if (tx_start !== 1'b0) ok = 1'b0;
            tick();
        end
        check({tag, ".no_start"}, 8'(ok), 8'h01);
    endtask

    initial begin
        logic ok;

        vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, op: 6'h20, res: 8'h08, bad: 1'b0};
        vecs[1] = '{a: 8'hF0, b: 8'h02, opb: 8'h03, op: 6'h03, res: 8'hFC, bad: 1'b0};
        vecs[2] = '{a: 8'hF0, b: 8'h02, opb: 8'h02, op: 6'h02, res: 8'h3C, bad: 1'b0};
        vecs[3] = '{a: 8'h11, b: 8'h22, opb: 8'h3F, op: 6'h3F, res: 8'h00, bad: 1'b1};
        vecs[4] = '{a: 8'h0F, b: 8'h3C, opb: 8'h24, op: 6'h24, res: 8'h0C, bad: 1'b0};
        vecs[5] = '{a: 8'h10, b: 8'h03, opb: 8'h22, op: 6'h22, res: 8'h0D, bad: 1'b0};
        vecs[6] = '{a: 8'hA0, b: 8'h05, opb: 8'h25, op: 6'h25, res: 8'hA5, bad: 1'b0};
        vecs[7] = '{a: 8'hFF, b: 8'h0F, opb: 8'h26, op: 6'h26, res: 8'hF0, bad: 1'b0};
        vecs[8] = '{a: 8'h01, b: 8'h02, opb: 8'h27, op: 6'h27, res: 8'hFC, bad: 1'b0};
        vecs[9] = '{a: 8'h7F, b: 8'h01, opb: 8'hE0, op: 6'h20, res: 8'h80, bad: 1'b0};

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        for (int i = 0; i < 10; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].opb,
                     vecs[i].op, vecs[i].res, vecs[i].bad);
        end

        // Partial frame abandoned: timeout fires after ten idle cycles in WAIT_B.
        send_byte(8'h07);
        ok = 1'b1;
        repeat (10) begin
            if (timeout !== 1'b0) ok = 1'b0;
            tick();
        end
        check("to.early", 8'(ok), 8'h01);
        check("to.pulse", 8'(timeout), 8'h01);
        tick();
        check("to.width", 8'(timeout), 8'h00);
        do_frame("after_to", 8'h01, 8'h01, 8'h22, 6'h22, 8'h00, 1'b0);

        // Byte on the expiry cycle is accepted instead of timing out.
        send_byte(8'h09);
        repeat (9) tick();
        send_byte(8'h04);
        check("edge.no_to", 8'(timeout), 8'h00);
        tick();
        check("edge.no_to2", 8'(timeout), 8'h00);
        tick();
        send_rest("edge", 8'h20, 8'h09, 8'h04, 6'h20, 8'h0D, 1'b0);

        // Bytes during EXEC, SEND, WAIT_DONE and with tx_done are dropped.
        send_byte(8'h05);
        tick();
        tick();
        send_byte(8'h03);
        tick();
        tick();
        send_byte(8'h20);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        tick();
        rx_data = 8'h99;
        check("ovr.exec", 8'(overrun), 8'h01);
        check("ovr.start", 8'(tx_start), 8'h01);
        tick();
        rx_valid = 1'b0;
        check("ovr.send", 8'(overrun), 8'h01);
        check("ovr.tx_data", tx_data, 8'h08);
        tick();
        check("ovr.clear", 8'(overrun), 8'h00);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        tx_done  = 1'b1;
        tick();
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        check("ovr.done", 8'(overrun), 8'h01);
        check("ovr.alu_a", alu_a, 8'h05);
        tick();
        check("ovr.clear2", 8'(overrun), 8'h00);
        do_frame("post_ovr", 8'h02, 8'h03, 8'h20, 6'h20, 8'h05, 1'b0);

        // Reset in WAIT_OP, following a bad-op frame so bad_op is set.
        do_frame("bad2", 8'h11, 8'h22, 8'h3F, 6'h3F, 8'h00, 1'b1);
        send_byte(8'h0A);
        tick();
        tick();
        send_byte(8'h0B);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_wop");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_no_start("rst_wop", 4);
        do_frame("post_rst_wop", 8'h06, 8'h02, 8'h22, 6'h22, 8'h04, 1'b0);

        // Reset in WAIT_DONE with a nonzero result pending.
        send_byte(8'h33);
        tick();
        tick();
        send_byte(8'h0C);
        tick();
        tick();
        send_byte(8'h26);
        tick();
        tick();
        check("rst_wd.pending", tx_data, 8'h3F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_wd");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_no_start("rst_wd", 4);
        do_frame("post_rst_wd", 8'hF0, 8'h02, 8'h03, 6'h03, 8'hFC, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
